// File: rtl/mini_cpu_pkg.sv
// -----------------------------------------------------------------------------
// mini_cpu_pkg
// Shared definitions for the mini_cpu_p core: opcode values, FSM state
// encodings, ALU operation codes and a small decode helper.
// -----------------------------------------------------------------------------
package mini_cpu_pkg;

    // Opcode field values (instruction bits [15:12]).
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_LDI  = 4'h3;
    localparam logic [3:0] OP_BCS  = 4'h4;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BNE  = 4'h9;
    localparam logic [3:0] OP_ADD  = 4'hA;
    localparam logic [3:0] OP_ADDI = 4'hB;
    localparam logic [3:0] OP_SUB  = 4'hC;
    localparam logic [3:0] OP_CMP  = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // FSM states; the encoding is visible on dbg_state.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    // ALU operations.
    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_PASS = 2'd2
    } alu_op_e;

    // Opcodes that write rd during WB.
    function automatic logic writes_rd(input logic [3:0] op);
        return (op == OP_LD)  || (op == OP_LDI) || (op == OP_ADD) ||
               (op == OP_ADDI) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/mini_cpu_alu.sv
// -----------------------------------------------------------------------------
// mini_cpu_alu
// Purely combinational ALU for mini_cpu_p.
//   a, b    : operands (DATA_W)
//   op      : ALU_ADD / ALU_SUB / ALU_PASS (passes b)
//   result  : DATA_W result
//   carry   : carry-out for add, borrow for sub, 0 for pass
//   zero    : result == 0
// -----------------------------------------------------------------------------
module mini_cpu_alu
    import mini_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    // One extra bit captures carry-out on add and borrow on sub: with both
    // operands zero-extended, the top bit of a-b is set exactly when a < b.
    logic [DATA_W:0] wide;

    always_comb begin
        wide = '0;
        case (op)
            ALU_ADD:  wide = {1'b0, a} + {1'b0, b};
            ALU_SUB:  wide = {1'b0, a} - {1'b0, b};
            ALU_PASS: wide = {1'b0, b};
            default:  wide = '0;
        endcase
    end

    assign result = wide[DATA_W-1:0];
    assign carry  = wide[DATA_W];
    assign zero   = (result == '0);

endmodule

// File: rtl/mini_cpu_p.sv
// -----------------------------------------------------------------------------
// mini_cpu_p
// Four-register, 16-bit-instruction, multi-cycle mini CPU core with data
// memory load/store over a req/ack handshake, Z/C flags and clean pause at
// instruction boundaries.
//
// Optional build macro: MINI_CPU_ILLEGAL_TRAP_EN
//   defined   - opcodes 5..7 halt the core and raise the sticky 'illegal' output
//   undefined - opcodes 5..7 execute as NOP and 'illegal' does not exist
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   en                run enable, sampled only in FETCH (0 = pause there)
//   imem_we/addr/wdata  instruction memory write port (only while paused)
//   rf_we/addr/wdata    register preload port (only while paused)
//   dmem_req/we/addr/wdata, dmem_rdata/ack   data memory handshake
//   PC, halt, zero_flag, carry_flag          architectural status
//   dbg_regs {r3,r2,r1,r0}, dbg_state        debug visibility
// -----------------------------------------------------------------------------
module mini_cpu_p
    import mini_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                imem_we,
    input  logic [PC_W-1:0]     imem_addr,
    input  logic [15:0]         imem_wdata,
    input  logic                rf_we,
    input  logic [1:0]          rf_addr,
    input  logic [DATA_W-1:0]   rf_wdata,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [DATA_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic [DATA_W-1:0]   dmem_rdata,
    input  logic                dmem_ack,
    output logic [PC_W-1:0]     PC,
    output logic                halt,
    output logic                zero_flag,
    output logic                carry_flag,
    output logic [4*DATA_W-1:0] dbg_regs,
    output logic [2:0]          dbg_state
`ifdef MINI_CPU_ILLEGAL_TRAP_EN
    ,
    output logic                illegal
`endif
);

    // ---------------------------------------------------------------- state
    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q,    pc_d;
    logic [15:0]       ir_q,    ir_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];
    // Holds the ALU result from EXEC (also the LD/ST address during MEM) and
    // is overwritten by load data on the ack cycle for WB.
    logic [DATA_W-1:0] res_q,   res_d;
    logic              z_q,     z_d;
    logic              c_q,     c_d;
`ifdef MINI_CPU_ILLEGAL_TRAP_EN
    logic              ill_q,   ill_d;
`endif

    logic [15:0]       imem [2**PC_W];

    // --------------------------------------------------------------- decode
    logic [3:0]        op;
    logic [1:0]        rd, rs;
    logic [7:0]        imm;
    logic [DATA_W-1:0] rd_val, rs_val;
    logic [DATA_W-1:0] imm_dw;
    logic [PC_W-1:0]   imm_pc;
    logic              paused;
    logic              branch_taken;

    assign op     = ir_q[15:12];
    assign rd     = ir_q[11:10];
    assign rs     = ir_q[9:8];
    assign imm    = ir_q[7:0];
    assign rd_val = regs_q[rd];
    assign rs_val = regs_q[rs];
    assign imm_dw = DATA_W'($signed(imm));
    assign imm_pc = PC_W'($signed(imm));

    // Loader ports are honoured only at a clean instruction boundary.
    assign paused = ((state_q == ST_FETCH) && !en) || (state_q == ST_HALT);

    always_comb begin
        case (op)
            OP_BCS:  branch_taken = c_q;
            OP_BEQ:  branch_taken = (rd_val == rs_val);
            OP_BNE:  branch_taken = (rd_val != rs_val);
            OP_JMP:  branch_taken = 1'b1;
            default: branch_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------ ALU
    logic [DATA_W-1:0] alu_a, alu_b, alu_res;
    alu_op_e           alu_op;
    logic              alu_carry, alu_zero;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        alu_a  = rd_val;
        alu_b  = rs_val;
        alu_op = ALU_ADD;
        case (op)
            OP_SUB, OP_CMP: alu_op = ALU_SUB;
            OP_ADDI:        alu_b  = imm_dw;
            OP_LD, OP_ST: begin
                alu_a = rs_val;
                alu_b = imm_dw;
            end
            OP_LDI: begin
                alu_op = ALU_PASS;
                alu_b  = imm_dw;
            end
            default: ;
        endcase
    end

    mini_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_res),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // ------------------------------------------------ next state / datapath
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        regs_d  = regs_q;
        res_d   = res_q;
        z_d     = z_q;
        c_d     = c_q;
`ifdef MINI_CPU_ILLEGAL_TRAP_EN
        ill_d   = ill_q;
`endif

        // Cannot collide with the WB write: WB is never a paused state.
        if (paused && rf_we) begin
            regs_d[rf_addr] = rf_wdata;
        end

        case (state_q)
            ST_FETCH: begin
                if (en) begin
                    ir_d    = imem[pc_q];
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (op == OP_HALT) begin
                    state_d = ST_HALT;
`ifdef MINI_CPU_ILLEGAL_TRAP_EN
                end else if (op inside {4'h5, 4'h6, 4'h7}) begin
                    state_d = ST_HALT;
                    ill_d   = 1'b1;
`endif
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d = alu_res;
                case (op)
                    OP_ADD, OP_ADDI, OP_SUB, OP_CMP: begin
                        z_d = alu_zero;
                        c_d = alu_carry;
                    end
                    OP_LDI:  z_d = alu_zero;
                    default: ;
                endcase
                // PC was already incremented in FETCH; wraps mod 2**PC_W.
                if (branch_taken) begin
                    pc_d = pc_q + imm_pc;
                end
                state_d = ((op == OP_LD) || (op == OP_ST)) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (op == OP_LD) begin
                        res_d   = dmem_rdata;
                        z_d     = (dmem_rdata == '0);
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                if (writes_rd(op)) begin
                    regs_d[rd] = res_q;
                end
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
`ifdef MINI_CPU_ILLEGAL_TRAP_EN
            ill_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            res_q   <= res_d;
            z_q     <= z_d;
            c_q     <= c_d;
            regs_q  <= regs_d;
`ifdef MINI_CPU_ILLEGAL_TRAP_EN
            ill_q   <= ill_d;
`endif
        end
    end

    // NOTE: the instruction memory has no reset; it is always loaded before
    // use, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (paused && imem_we) begin
            imem[imem_addr] <= imem_wdata;
        end
    end

    // -------------------------------------------------------------- outputs
    // Request follows the MEM state, so a reset during MEM drops it one
    // cycle later along with the state.
    assign dmem_req   = (state_q == ST_MEM);
    assign dmem_we    = dmem_req && (op == OP_ST);
    assign dmem_addr  = res_q;
    assign dmem_wdata = rd_val;

    assign PC         = pc_q;
    assign halt       = (state_q == ST_HALT);
    assign zero_flag  = z_q;
    assign carry_flag = c_q;
    assign dbg_regs   = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};
    assign dbg_state  = state_q;
`ifdef MINI_CPU_ILLEGAL_TRAP_EN
    assign illegal    = ill_q;
`endif

endmodule

// File: tb/tb_mini_cpu_p.sv
module tb_mini_cpu_p;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: DATA_W=8, PC_W=8
    logic        en = 1'b0;
    logic        a_imem_we = 1'b0;
    logic [7:0]  a_imem_addr = '0;
    logic [15:0] a_imem_wdata = '0;
    logic        a_rf_we = 1'b0;
    logic [1:0]  a_rf_addr = '0;
    logic [7:0]  a_rf_wdata = '0;
    logic        a_req, a_we, a_ack;
    logic [7:0]  a_addr, a_wdata, a_rdata, a_pc;
    logic        a_halt, a_z, a_c;
    logic [31:0] a_regs;
    logic [2:0]  a_state;
`ifdef MINI_CPU_ILLEGAL_TRAP_EN
    logic        a_ill;
    logic        b_ill;
`endif

    mini_cpu_p #(.DATA_W(8), .PC_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en),
        .imem_we(a_imem_we), .imem_addr(a_imem_addr), .imem_wdata(a_imem_wdata),
        .rf_we(a_rf_we), .rf_addr(a_rf_addr), .rf_wdata(a_rf_wdata),
        .dmem_req(a_req), .dmem_we(a_we), .dmem_addr(a_addr), .dmem_wdata(a_wdata),
        .dmem_rdata(a_rdata), .dmem_ack(a_ack),
        .PC(a_pc), .halt(a_halt), .zero_flag(a_z), .carry_flag(a_c),
        .dbg_regs(a_regs), .dbg_state(a_state)
`ifdef MINI_CPU_ILLEGAL_TRAP_EN
        , .illegal(a_ill)
`endif
    );

    // ---------------- DUT B: DATA_W=16, PC_W=4 (no memory traffic)
    logic        b_en = 1'b0;
    logic        b_imem_we = 1'b0;
    logic [3:0]  b_imem_addr = '0;
    logic [15:0] b_imem_wdata = '0;
    logic        b_rf_we = 1'b0;
    logic [1:0]  b_rf_addr = '0;
    logic [15:0] b_rf_wdata = '0;
    logic        b_req, b_we;
    logic [15:0] b_addr, b_wdata;
    logic [15:0] b_rdata = '0;
    logic        b_ack = 1'b1;
    logic [3:0]  b_pc;
    logic        b_halt, b_z, b_c;
    logic [63:0] b_regs;
    logic [2:0]  b_state;

    mini_cpu_p #(.DATA_W(16), .PC_W(4)) dut_b (
        .clk(clk), .rst(rst), .en(b_en),
        .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
        .rf_we(b_rf_we), .rf_addr(b_rf_addr), .rf_wdata(b_rf_wdata),
        .dmem_req(b_req), .dmem_we(b_we), .dmem_addr(b_addr), .dmem_wdata(b_wdata),
        .dmem_rdata(b_rdata), .dmem_ack(b_ack),
        .PC(b_pc), .halt(b_halt), .zero_flag(b_z), .carry_flag(b_c),
        .dbg_regs(b_regs), .dbg_state(b_state)
`ifdef MINI_CPU_ILLEGAL_TRAP_EN
        , .illegal(b_ill)
`endif
    );

    // ---------------- data memory responder for DUT A
    // Unwritten locations read a seed-dependent pattern; a generation tag
    // marks locations stored during the current program.
    int         cur_gen  = 1;
    int         cur_seed = 0;
    int         a_waits [64];
    logic [7:0] a_mem   [256];
    int         a_gen   [256];
    int         a_cnt = 0, a_widx = 0, a_nlog = 0;
    logic       log_we   [16];
    logic [7:0] log_addr [16];
    int         log_len  [16];

    function automatic logic [7:0] init_val(input int addr, input int seed);
        return 8'(addr * 37 + seed);
    endfunction

    always_comb begin
        a_rdata = init_val(int'(a_addr), cur_seed);
        if (a_gen[a_addr] == cur_gen) a_rdata = a_mem[a_addr];
    end

    assign a_ack = a_req && (a_cnt == a_waits[a_widx]);

    always @(posedge clk) begin
        if (rst) begin
            a_cnt  <= 0;
            a_widx <= 0;
            a_nlog <= 0;
        end else if (a_req && a_ack) begin
            if (a_we) begin
                a_mem[a_addr] <= a_wdata;
                a_gen[a_addr] <= cur_gen;
            end
            log_we[a_nlog & 15]   <= a_we;
            log_addr[a_nlog & 15] <= a_addr;
            log_len[a_nlog & 15]  <= a_cnt + 1;
            a_nlog <= a_nlog + 1;
            a_widx <= (a_widx + 1) & 63;
            a_cnt  <= 0;
        end else if (a_req) begin
            a_cnt <= a_cnt + 1;
        end else begin
            a_cnt <= 0;
        end
    end

    // ---------------- ISA-level reference model
    logic [15:0] prog [256];
    int m_regs [4];
    int m_mem  [256];
    int m_pc, m_z, m_c, m_halt, m_ill;

    task automatic model_run(input int w, input int pw, output int cycles);
        int mask, pmask, widx, ins, op, rd, rs, imm, sx, a, b, r, addr;
        mask   = (1 << w) - 1;
        pmask  = (1 << pw) - 1;
        widx   = 0;
        cycles = 0;
        for (int step = 0; step < 2000 && m_halt == 0; step++) begin
            ins  = int'(prog[m_pc]);
            op   = (ins >> 12) & 15;
            rd   = (ins >> 10) & 3;
            rs   = (ins >> 8) & 3;
            imm  = ins & 255;
            sx   = (imm >= 128) ? imm - 256 : imm;
            a    = m_regs[rd];
            b    = m_regs[rs];
            m_pc = (m_pc + 1) & pmask;
            case (op)
                1: begin
                    addr = (b + sx) & mask;
                    r = m_mem[addr];
                    m_regs[rd] = r; m_z = (r == 0) ? 1 : 0;
                    cycles += 5 + a_waits[widx]; widx++;
                end
                2: begin
                    addr = (b + sx) & mask;
                    m_mem[addr] = a;
                    cycles += 4 + a_waits[widx]; widx++;
                end
                3: begin
                    r = sx & mask; m_regs[rd] = r; m_z = (r == 0) ? 1 : 0; cycles += 4;
                end
                4:  begin if (m_c != 0) m_pc = (m_pc + sx) & pmask; cycles += 4; end
                8:  begin if (a == b) m_pc = (m_pc + sx) & pmask; cycles += 4; end
                9:  begin if (a != b) m_pc = (m_pc + sx) & pmask; cycles += 4; end
                10, 11: begin
                    r = a + ((op == 10) ? b : (sx & mask));
                    m_c = (r > mask) ? 1 : 0; r = r & mask;
                    m_regs[rd] = r; m_z = (r == 0) ? 1 : 0; cycles += 4;
                end
                12, 13: begin
                    m_c = (a < b) ? 1 : 0; r = (a - b) & mask; m_z = (r == 0) ? 1 : 0;
                    if (op == 12) m_regs[rd] = r;
                    cycles += 4;
                end
                14: begin m_pc = (m_pc + sx) & pmask; cycles += 4; end
                15: begin m_halt = 1; cycles += 2; end
                5, 6, 7: begin
`ifdef MINI_CPU_ILLEGAL_TRAP_EN
                    m_halt = 1; m_ill = 1; cycles += 2;
`else
                    cycles += 4;
`endif
                end
                default: cycles += 4;
            endcase
        end
    endtask

    // ---------------- helpers
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0; b_en = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int imm);
        return 16'((op << 12) | (rd << 10) | (rs << 8) | (imm & 255));
    endfunction

    task automatic a_load(input int n);
        for (int i = 0; i < n; i++) begin
            a_imem_we = 1'b1; a_imem_addr = 8'(i); a_imem_wdata = prog[i];
            tick();
        end
        a_imem_we = 1'b0;
    endtask

    task automatic a_setreg(input int idx, input int val);
        a_rf_we = 1'b1; a_rf_addr = 2'(idx); a_rf_wdata = 8'(val);
        tick();
        a_rf_we = 1'b0;
    endtask

    task automatic a_run(output int cyc);
        en  = 1'b1;
        cyc = 0;
        while (!a_halt && cyc < 3000) begin
            tick(); cyc++;
        end
        en = 1'b0;
    endtask

    task automatic b_load();
        for (int i = 0; i < 16; i++) begin
            b_imem_we = 1'b1; b_imem_addr = 4'(i); b_imem_wdata = prog[i];
            tick();
        end
        b_imem_we = 1'b0;
    endtask

    task automatic b_setreg(input int idx, input int val);
        b_rf_we = 1'b1; b_rf_addr = 2'(idx); b_rf_wdata = 16'(val);
        tick();
        b_rf_we = 1'b0;
    endtask

    task automatic b_run(output int cyc);
        b_en = 1'b1;
        cyc  = 0;
        while (!b_halt && cyc < 3000) begin
            tick(); cyc++;
        end
        b_en = 1'b0;
    endtask

    // Random body of n instructions followed by HALTs; branches only jump
    // forward (offset 0..3) so every program terminates.
    task automatic gen_prog(input int n, input bit allow_mem);
        int op;
        for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
        for (int i = 0; i < n; i++) begin
            do begin
                op = int'($urandom_range(0, 14));
            end while ((!allow_mem && (op == 1 || op == 2)) ||
                       (op >= 5 && op <= 7 && $urandom_range(0, 3) != 0));
            if (op == 4 || op == 8 || op == 9 || op == 14)
                prog[i] = enc(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                              int'($urandom_range(0, 3)));
            else
                prog[i] = enc(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                              int'($urandom_range(0, 255)));
        end
    endtask

    // ---------------- stimulus
    initial begin
        int cyc, exp_cyc, nmis, v;
        logic [7:0] dv;

        for (int i = 0; i < 64; i++) a_waits[i] = 0;

        // Reset state
        do_reset();
        check("rst_pc", a_pc, 0);
        check("rst_state", a_state, 0);
        check("rst_regs", a_regs, 0);
        check("rst_z", a_z, 0);
        check("rst_c", a_c, 0);
        check("rst_halt", a_halt, 0);
        check("rst_req", a_req, 0);
        check("rst_we", a_we, 0);
        check("rst_b_state", b_state, 0);
        check("rst_b_req", b_req, 0);

        // ADD r0,r1 ; HALT
        prog[0] = 16'hA100; prog[1] = 16'hF000;
        a_load(2);
        a_setreg(0, 8'h11); a_setreg(1, 8'h22);
        a_run(cyc);
        check("add_cycles", cyc, 6);
        check("add_r0", a_regs[7:0], 8'h33);
        check("add_z", a_z, 0);
        check("add_c", a_c, 0);
        check("add_halt", a_halt, 1);
        check("add_pc", a_pc, 2);

        // ADDI r2,1 with r2=FF ; BCS +2 skips two LDIs
        do_reset();
        prog[0] = 16'hB801; prog[1] = 16'h4002; prog[2] = 16'h3C55;
        prog[3] = 16'h3C66; prog[4] = 16'hF000;
        a_load(5);
        a_setreg(2, 8'hFF);
        en = 1'b1;
        repeat (8) tick();
        check("bcs_pc", a_pc, 4);
        check("bcs_state", a_state, 0);
        check("addi_r2", a_regs[23:16], 8'h00);
        check("addi_z", a_z, 1);
        check("addi_c", a_c, 1);
        a_run(cyc);
        check("bcs_halt_cycles", cyc, 2);
        check("bcs_r3_untouched", a_regs[31:24], 8'h00);

        // ST r1,[r0+4] ; LD r3,[r0+4] with ack on the 3rd request cycle
        do_reset();
        cur_gen++; cur_seed = 0;
        a_waits[0] = 2; a_waits[1] = 2;
        prog[0] = 16'h2404; prog[1] = 16'h1C04; prog[2] = 16'hF000;
        a_load(3);
        a_setreg(0, 8'h10); a_setreg(1, 8'hA5);
        a_run(cyc);
        check("mem_cycles", cyc, 15);
        check("mem_nacc", a_nlog, 2);
        check("st_we", log_we[0], 1);
        check("st_addr", log_addr[0], 8'h14);
        check("st_reqlen", log_len[0], 3);
        check("ld_we", log_we[1], 0);
        check("ld_addr", log_addr[1], 8'h14);
        check("ld_reqlen", log_len[1], 3);
        check("ld_r3", a_regs[31:24], 8'hA5);
        check("ld_z", a_z, 0);

        // Pause during EXEC of SUB; imem write while running is ignored
        do_reset();
        prog[0] = 16'hC100; prog[1] = 16'hAB00; prog[2] = 16'hF000;
        a_load(3);
        a_setreg(0, 8'h50); a_setreg(1, 8'h20); a_setreg(2, 8'h03); a_setreg(3, 8'h04);
        en = 1'b1;
        a_imem_we = 1'b1; a_imem_addr = 8'd1; a_imem_wdata = 16'hF000;
        tick(); tick();
        a_imem_we = 1'b0;
        en = 1'b0;
        check("pause_in_exec", a_state, 2);
        repeat (5) tick();
        check("pause_state", a_state, 0);
        check("pause_pc", a_pc, 1);
        check("pause_sub_r0", a_regs[7:0], 8'h30);
        a_setreg(3, 8'h07);
        check("pause_rf_we", a_regs[31:24], 8'h07);
        a_run(cyc);
        check("resume_cycles", cyc, 6);
        check("resume_r2", a_regs[23:16], 8'h0A);
        check("resume_pc", a_pc, 3);

        // Reset while MEM has an outstanding request
        do_reset();
        a_waits[0] = 1000;
        prog[0] = 16'h2404; prog[1] = 16'hF000;
        a_load(2);
        a_setreg(0, 1); a_setreg(1, 2);
        en = 1'b1;
        repeat (3) tick();
        check("mem_req_high", a_req, 1);
        check("mem_req_we", a_we, 1);
        check("mem_req_addr", a_addr, 8'h05);
        en = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmem_req", a_req, 0);
        check("rstmem_pc", a_pc, 0);
        check("rstmem_regs", a_regs, 0);
        check("rstmem_state", a_state, 0);
        a_waits[0] = 0;

        // Opcode 6
        do_reset();
        prog[0] = 16'h6000; prog[1] = 16'h3001; prog[2] = 16'hF000;
        a_load(3);
        a_run(cyc);
`ifdef MINI_CPU_ILLEGAL_TRAP_EN
        check("trap_cycles", cyc, 2);
        check("trap_halt", a_halt, 1);
        check("trap_illegal", a_ill, 1);
        check("trap_pc", a_pc, 1);
`else
        check("op6_cycles", cyc, 10);
        check("op6_r0", a_regs[7:0], 8'h01);
        check("op6_pc", a_pc, 3);
`endif

        // Randomized programs on DUT A against the model
        for (int p = 0; p < 12; p++) begin
            do_reset();
            cur_gen++;
            cur_seed = int'($urandom_range(0, 255));
            for (int i = 0; i < 64; i++) a_waits[i] = int'($urandom_range(0, 3));
            gen_prog(16, 1'b1);
            a_load(20);
            for (int i = 0; i < 4; i++) begin
                v = int'($urandom_range(0, 255));
                a_setreg(i, v);
                m_regs[i] = v;
            end
            for (int i = 0; i < 256; i++) m_mem[i] = int'(init_val(i, cur_seed));
            m_pc = 0; m_z = 0; m_c = 0; m_halt = 0; m_ill = 0;
            model_run(8, 8, exp_cyc);
            a_run(cyc);
            check($sformatf("rnd%0d_cycles", p), cyc, exp_cyc);
            check($sformatf("rnd%0d_regs", p), a_regs,
                  {8'(m_regs[3]), 8'(m_regs[2]), 8'(m_regs[1]), 8'(m_regs[0])});
            check($sformatf("rnd%0d_pc", p), a_pc, m_pc);
            check($sformatf("rnd%0d_z", p), a_z, m_z);
            check($sformatf("rnd%0d_c", p), a_c, m_c);
            check($sformatf("rnd%0d_halt", p), a_halt, 1);
            nmis = 0;
            for (int i = 0; i < 256; i++) begin
                dv = (a_gen[i] == cur_gen) ? a_mem[i] : init_val(i, cur_seed);
                if (int'(dv) != m_mem[i]) nmis++;
            end
            check($sformatf("rnd%0d_mem_mismatches", p), nmis, 0);
        end

        // DUT B: LDI sign extension to 16 bits and PC wrap modulo 16
        do_reset();
        for (int i = 0; i < 16; i++) prog[i] = 16'hF000;
        prog[0] = 16'h3080; prog[1] = 16'hE00D; prog[15] = 16'hE002;
        b_load();
        b_run(cyc);
        check("b_wrap_cycles", cyc, 14);
        check("b_wrap_pc", b_pc, 3);
        check("b_ldi_sext", b_regs[15:0], 16'hFF80);
        check("b_halt", b_halt, 1);

        // Randomized programs on DUT B (register/branch only)
        for (int p = 0; p < 4; p++) begin
            do_reset();
            gen_prog(10, 1'b0);
            b_load();
            for (int i = 0; i < 4; i++) begin
                v = int'($urandom_range(0, 65535));
                b_setreg(i, v);
                m_regs[i] = v;
            end
            m_pc = 0; m_z = 0; m_c = 0; m_halt = 0; m_ill = 0;
            model_run(16, 4, exp_cyc);
            b_run(cyc);
            check($sformatf("brnd%0d_cycles", p), cyc, exp_cyc);
            check($sformatf("brnd%0d_regs", p), b_regs,
                  {16'(m_regs[3]), 16'(m_regs[2]), 16'(m_regs[1]), 16'(m_regs[0])});
            check($sformatf("brnd%0d_pc", p), b_pc, m_pc);
            check($sformatf("brnd%0d_z", p), b_z, m_z);
            check($sformatf("brnd%0d_c", p), b_c, m_c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
